// File: rtl/eth_upload_ram_wr.sv
// Application-side writer for the Ethernet upload RAM: packs a word stream into RAM from address 0,
// kicks the transmitter, then holds off input until it is done. Optional zero padding: ETH_UPLOAD_PAD_EN.
module eth_upload_ram_wr #(
    parameter int MAX_WORDS   = 360,
    parameter int ACK_TIMEOUT = 255,
    parameter int MIN_WORDS   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] app_data,
    input  logic        app_valid,
    input  logic        app_last,
    output logic        app_ready,
    output logic [8:0]  upload_ram_waddr,
    output logic [31:0] upload_ram_wdata,
    output logic        upload_ram_wren,
    output logic [8:0]  tx_data_len,
    output logic        tx_data_en,
    input  logic        tx_busy,
    output logic [15:0] trunc_cnt,
    output logic [15:0] timeout_cnt
);

    if (MAX_WORDS < 1 || MAX_WORDS > 511) begin : g_bad_max_words
        $error("MAX_WORDS must lie in 1..511");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
        $error("ACK_TIMEOUT must be at least 1");
    end
    if (MIN_WORDS < 1 || MIN_WORDS > MAX_WORDS) begin : g_bad_min_words
        $error("MIN_WORDS must lie in 1..MAX_WORDS");
    end

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [8:0]    LAST_IDX  = 9'(MAX_WORDS - 1);
    localparam logic [TW-1:0] TIMER_END = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_DROP,
        S_PAD,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

`ifdef ETH_UPLOAD_PAD_EN
    localparam logic [8:0] PAD_TARGET = 9'(MIN_WORDS);
    localparam state_t     END_STATE  = S_PAD;
`else
    localparam state_t     END_STATE  = S_ISSUE;
`endif

    state_t        state_q, state_d;
    logic [8:0]    count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          ready_q;
    logic          xfer;
    logic          wr_d;
    logic [8:0]    waddr_d;
    logic [31:0]   wdata_d;
    logic          trunc_inc;
    logic          timeout_inc;

    // Input is only taken while filling or draining a truncated packet, and never in the cycle after reset.
    assign app_ready   = ready_q && (state_q == S_FILL || state_q == S_DROP);
    assign xfer        = app_valid && app_ready;
    assign tx_data_en  = (state_q == S_ISSUE);
    assign tx_data_len = (state_q == S_ISSUE || state_q == S_WAIT_ACK || state_q == S_WAIT_DONE)
                         ? count_q : 9'd0;

    // NOTE: every signal driven here gets a default before the case; a path that skips one infers a latch.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        timer_d     = timer_q;
        wr_d        = 1'b0;
        waddr_d     = count_q;
        wdata_d     = app_data;
        trunc_inc   = 1'b0;
        timeout_inc = 1'b0;
        case (state_q)
            S_FILL: begin
                if (xfer) begin
                    wr_d    = 1'b1;
                    count_d = count_q + 9'd1;
                    if (app_last) begin
                        state_d = END_STATE;
                    end else if (count_q == LAST_IDX) begin
                        state_d   = S_DROP;
                        trunc_inc = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (xfer && app_last) begin
                    state_d = END_STATE;
                end
            end
`ifdef ETH_UPLOAD_PAD_EN
            S_PAD: begin
                if (count_q < PAD_TARGET) begin
                    wr_d    = 1'b1;
                    wdata_d = 32'd0;
                    count_d = count_q + 9'd1;
                    if (count_q == PAD_TARGET - 9'd1) begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
`endif
            S_ISSUE: begin
                state_d = S_WAIT_ACK;
                timer_d = '0;
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TIMER_END) begin
                    state_d     = S_FILL;
                    count_d     = 9'd0;
                    timeout_inc = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_FILL;
                    count_d = 9'd0;
                end
            end
            default: begin
                state_d = S_FILL;
                count_d = 9'd0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
            count_q <= 9'd0;
            timer_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            ready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upload_ram_wren  <= 1'b0;
            upload_ram_waddr <= 9'd0;
            upload_ram_wdata <= 32'd0;
        end else begin
            upload_ram_wren <= wr_d;
            if (wr_d) begin
                upload_ram_waddr <= waddr_d;
                upload_ram_wdata <= wdata_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trunc_cnt   <= 16'd0;
            timeout_cnt <= 16'd0;
        end else begin
            if (trunc_inc && trunc_cnt != 16'hFFFF) begin
                trunc_cnt <= trunc_cnt + 16'd1;
            end
            if (timeout_inc && timeout_cnt != 16'hFFFF) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_upload_ram_wr.sv
// Self-checking bench for eth_upload_ram_wr: random packets compared against a list-level model of
// what must land in RAM and what length must be handed to the transmitter.
module tb_eth_upload_ram_wr;

    localparam int MAX_WORDS   = 360;
    localparam int ACK_TIMEOUT = 255;
    localparam int MIN_WORDS   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] app_data = 32'd0;
    logic        app_valid = 1'b0;
    logic        app_last = 1'b0;
    logic        app_ready;
    logic [8:0]  upload_ram_waddr;
    logic [31:0] upload_ram_wdata;
    logic        upload_ram_wren;
    logic [8:0]  tx_data_len;
    logic        tx_data_en;
    logic        tx_busy = 1'b0;
    logic [15:0] trunc_cnt;
    logic [15:0] timeout_cnt;

    eth_upload_ram_wr #(
        .MAX_WORDS  (MAX_WORDS),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .MIN_WORDS  (MIN_WORDS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .app_data        (app_data),
        .app_valid       (app_valid),
        .app_last        (app_last),
        .app_ready       (app_ready),
        .upload_ram_waddr(upload_ram_waddr),
        .upload_ram_wdata(upload_ram_wdata),
        .upload_ram_wren (upload_ram_wren),
        .tx_data_len     (tx_data_len),
        .tx_data_en      (tx_data_en),
        .tx_busy         (tx_busy),
        .trunc_cnt       (trunc_cnt),
        .timeout_cnt     (timeout_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    int          en_len_q[$];
    logic [31:0] pkt_q[$];
    int          stall_q[$];

    always @(negedge clk) begin
        if (upload_ram_wren) wr_q.push_back('{upload_ram_waddr, upload_ram_wdata});
        if (tx_data_en) en_len_q.push_back(int'(tx_data_len));
    end

    function automatic int exp_len(input int n);
        int k;
        k = (n < MAX_WORDS) ? n : MAX_WORDS;
`ifdef ETH_UPLOAD_PAD_EN
        if (k < MIN_WORDS) k = MIN_WORDS;
`endif
        return k;
    endfunction

    task automatic clear_logs();
        wr_q.delete();
        en_len_q.delete();
        stall_q.delete();
    endtask

    task automatic make_pkt(input int n);
        pkt_q.delete();
        for (int i = 0; i < n; i++) pkt_q.push_back($urandom);
    endtask

    // Offers pkt_q[0..n_send-1]; each word is held until app_ready is seen. Time stays just after a negedge.
    task automatic send_pkt(input int n_send, input bit gaps, input bit with_last);
        int  stall;
        bit  rdy;
        for (int i = 0; i < n_send; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) begin
                    app_valid = 1'b0;
                    app_last  = 1'b0;
                    @(negedge clk);
                end
            end
            app_valid = 1'b1;
            app_data  = pkt_q[i];
            app_last  = with_last && (i == n_send - 1);
            stall = 0;
            forever begin
                rdy = app_ready;
                @(negedge clk);
                if (rdy) break;
                stall++;
                if (stall > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_stall word=%0d got app_ready=0 for %0d cycles, want <=200", i, stall);
                    app_valid = 1'b0;
                    app_last  = 1'b0;
                    return;
                end
            end
            stall_q.push_back(stall);
        end
        app_valid = 1'b0;
        app_last  = 1'b0;
    endtask

    task automatic check_writes(input string name, input int n_sent);
        int  n_keep;
        int  n_exp;
        int  bad;
        wr_t w;
        logic [31:0] d;
        n_keep = (n_sent < MAX_WORDS) ? n_sent : MAX_WORDS;
        n_exp  = exp_len(n_sent);
        checks++;
        if (wr_q.size() != n_exp) begin
            errors++;
            $display("FAIL %s_write_count got %0d want %0d", name, wr_q.size(), n_exp);
            return;
        end
        bad = -1;
        for (int i = 0; i < n_exp; i++) begin
            w = wr_q[i];
            d = (i < n_keep) ? pkt_q[i] : 32'd0;
            if (bad < 0 && (w.addr !== 9'(i) || w.data !== d)) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            w = wr_q[bad];
            d = (bad < n_keep) ? pkt_q[bad] : 32'd0;
            $display("FAIL %s_write[%0d] got addr=%0d data=%08h want addr=%0d data=%08h",
                     name, bad, w.addr, w.data, bad, d);
        end
    endtask

    // Waits (bounded) for the start pulse and checks its length and single-cycle width.
    task automatic check_issue(input string name, input int want_len);
        int n;
        n = 0;
        #1;
        while (en_len_q.size() == 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #1;
        checks++;
        if (en_len_q.size() != 1) begin
            errors++;
            $display("FAIL %s_en_pulses got %0d cycles want 1", name, en_len_q.size());
            return;
        end
        checks++;
        if (en_len_q[0] != want_len) begin
            errors++;
            $display("FAIL %s_len got %0d want %0d", name, en_len_q[0], want_len);
        end
    endtask

    task automatic finish_tx(input string name, input int busy_cycles, input int want_len);
        tx_busy = 1'b1;
        repeat (busy_cycles) @(negedge clk);
        checks++;
        if (tx_data_len !== 9'(want_len) || app_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_hold got len=%0d ready=%b want len=%0d ready=0",
                     name, tx_data_len, app_ready, want_len);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (app_ready !== 1'b1 || tx_data_len !== 9'd0) begin
            errors++;
            $display("FAIL %s_release got ready=%b len=%0d want ready=1 len=0",
                     name, app_ready, tx_data_len);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({app_ready, upload_ram_waddr, upload_ram_wdata, upload_ram_wren, tx_data_len,
             tx_data_en, trunc_cnt, timeout_cnt} !== '0) begin
            errors++;
            $display("FAIL %s_outputs got ready=%b waddr=%0d wdata=%08h wren=%b len=%0d en=%b trunc=%0d tmo=%0d want all 0",
                     name, app_ready, upload_ram_waddr, upload_ram_wdata, upload_ram_wren,
                     tx_data_len, tx_data_en, trunc_cnt, timeout_cnt);
        end
    endtask

    task automatic release_reset(input string name);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (app_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_first_cycle got %b want 0", name, app_ready);
        end
        @(negedge clk);
        checks++;
        if (app_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_after got %b want 1", name, app_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        release_reset("reset");
    endtask

    task automatic test_basic();
        clear_logs();
        pkt_q.delete();
        pkt_q.push_back(32'h11);
        pkt_q.push_back(32'h22);
        pkt_q.push_back(32'h33);
        pkt_q.push_back(32'h44);
        send_pkt(4, 1'b0, 1'b1);
        check_issue("basic", exp_len(4));
        check_writes("basic", 4);
        finish_tx("basic", 10, exp_len(4));
    endtask

    task automatic test_single_word();
        clear_logs();
        make_pkt(1);
        send_pkt(1, 1'b0, 1'b1);
        check_issue("single", exp_len(1));
        check_writes("single", 1);
        finish_tx("single", 4, exp_len(1));
    endtask

    task automatic test_truncation();
        int bad;
        clear_logs();
        make_pkt(MAX_WORDS + 5);
        send_pkt(MAX_WORDS + 5, 1'b0, 1'b1);
        check_issue("trunc", MAX_WORDS);
        check_writes("trunc", MAX_WORDS + 5);
        bad = 0;
        for (int i = MAX_WORDS; i < stall_q.size(); i++) bad += stall_q[i];
        checks++;
        if (stall_q.size() != MAX_WORDS + 5 || bad != 0) begin
            errors++;
            $display("FAIL trunc_drain got words=%0d stalls=%0d want words=%0d stalls=0",
                     stall_q.size(), bad, MAX_WORDS + 5);
        end
        checks++;
        if (trunc_cnt !== 16'd1) begin
            errors++;
            $display("FAIL trunc_cnt got %0d want 1", trunc_cnt);
        end
        finish_tx("trunc", 3, MAX_WORDS);

        clear_logs();
        make_pkt(MAX_WORDS);
        send_pkt(MAX_WORDS, 1'b0, 1'b1);
        check_issue("exact_max", MAX_WORDS);
        check_writes("exact_max", MAX_WORDS);
        checks++;
        if (trunc_cnt !== 16'd1) begin
            errors++;
            $display("FAIL exact_max_trunc_cnt got %0d want 1", trunc_cnt);
        end
        finish_tx("exact_max", 2, MAX_WORDS);
    endtask

    task automatic test_timeout();
        int n;
        clear_logs();
        make_pkt(3);
        send_pkt(3, 1'b0, 1'b1);
        check_issue("timeout", exp_len(3));
        // check_issue returns one cycle after the pulse
        n = 1;
        repeat (ACK_TIMEOUT - 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (timeout_cnt !== 16'd0 || app_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got cnt=%0d ready=%b at %0d cycles want cnt=0 ready=0",
                     timeout_cnt, app_ready, n);
        end
        while (app_ready !== 1'b1 && n < ACK_TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < ACK_TIMEOUT || n > ACK_TIMEOUT + 2 || timeout_cnt !== 16'd1 || tx_data_len !== 9'd0) begin
            errors++;
            $display("FAIL timeout_return got cycles=%0d cnt=%0d len=%0d want cycles %0d..%0d cnt=1 len=0",
                     n, timeout_cnt, tx_data_len, ACK_TIMEOUT, ACK_TIMEOUT + 2);
        end

        // busy already high while filling and at issue time
        clear_logs();
        make_pkt(2);
        tx_busy = 1'b1;
        send_pkt(2, 1'b0, 1'b1);
        check_issue("busy_early", exp_len(2));
        check_writes("busy_early", 2);
        finish_tx("busy_early", 2, exp_len(2));
        checks++;
        if (timeout_cnt !== 16'd1) begin
            errors++;
            $display("FAIL busy_early_timeout_cnt got %0d want 1", timeout_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        make_pkt(8);
        send_pkt(3, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_outputs_zero("reset_mid");
        en_len_q.delete();
        repeat (2) @(negedge clk);
        release_reset("reset_mid");
        repeat (5) @(negedge clk);
        checks++;
        if (en_len_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_no_issue got %0d pulses want 0", en_len_q.size());
        end
        clear_logs();
        make_pkt(2);
        send_pkt(2, 1'b0, 1'b1);
        check_issue("after_reset", exp_len(2));
        check_writes("after_reset", 2);
        finish_tx("after_reset", 5, exp_len(2));
    endtask

    task automatic test_gaps();
        clear_logs();
        make_pkt(100);
        send_pkt(100, 1'b1, 1'b1);
        check_issue("gaps", exp_len(100));
        check_writes("gaps", 100);
        finish_tx("gaps", 7, exp_len(100));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_word();
        test_truncation();
        test_timeout();
        test_reset_mid();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got no end of test want finish before 2ms");
        $fatal(1);
    end

endmodule

// File: doc/eth_upload_ram_wr.md
Name: eth_upload_ram_wr

Overview:
- Application-side writer for the Ethernet upload RAM; the producer end of the path whose transmitter reads upload RAM and is kicked by tx_data_en/tx_data_len.
- Accepts a 32-bit word stream with end-of-packet marker and writes words into the upload RAM from address 0.
- Hands the completed packet to the Ethernet transmitter, then blocks new input until the transmitter has finished reading.

Parameters:
- MAX_WORDS, 360, maximum words per packet (1440 bytes); legal range 1..511.
- ACK_TIMEOUT, 255, cycles to wait for tx_busy rise after tx_data_en before abandoning the packet.
- MIN_WORDS, 16, minimum packet length when padding is compiled in.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- app_data  in  32  stream word.
- app_valid  in  1  app_data valid.
- app_last  in  1  qualifies the final word of a packet when app_valid=1.
- app_ready  out  1  block accepts a word this cycle (transfer = app_valid & app_ready).
- upload_ram_waddr  out  9  RAM write address.
- upload_ram_wdata  out  32  RAM write data.
- upload_ram_wren  out  1  RAM write enable.
- tx_data_len  out  9  packet length in words, stable from tx_data_en until return to FILL.
- tx_data_en  out  1  one-cycle start pulse to the transmitter.
- tx_busy  in  1  transmitter is reading the upload RAM.
- trunc_cnt  out  16  saturating count of packets truncated at MAX_WORDS.
- timeout_cnt  out  16  saturating count of ACK timeouts.

Behaviour:
- Reset (async): state=FILL; word counter=0; all outputs 0; app_ready=0 for the first cycle after reset release, then 1.
- States:
  - FILL: app_ready=1. Each transfer registers wren=1, waddr=count, wdata=app_data on the next cycle, then count++. Write latency is 1 cycle.
  - FILL exits on a transfer with app_last=1, or on a transfer making count==MAX_WORDS (truncation: trunc_cnt++, and input is dropped until the word carrying app_last, with app_ready=1 throughout the drop so the source drains). Exit goes to ISSUE (with padding, PAD first).
  - ISSUE: app_ready=0; tx_data_len=count; tx_data_en=1 for exactly one cycle; go to WAIT_ACK.
  - WAIT_ACK: a timer counts up. On tx_busy=1, go to WAIT_DONE. If the timer reaches ACK_TIMEOUT, timeout_cnt++ and go to FILL.
  - WAIT_DONE: on tx_busy=0, go to FILL. Entering FILL clears count and tx_data_len.
  - DROP: sub-state of FILL after truncation; wren stays 0. On app_last it goes to ISSUE with count=MAX_WORDS.
- Boundaries:
  - app_last on the first word gives len=1.
  - app_last coincident with count reaching MAX_WORDS is a normal end, not a truncation.
  - app_valid low in FILL means no write and the counter holds.
  - tx_busy already high in ISSUE is accepted in WAIT_ACK on the next cycle.
  - tx_busy high while in FILL is ignored.
  - RAM addresses never exceed MAX_WORDS-1.
  - Counters saturate at 0xFFFF.
  - Reset mid-packet discards the partial packet, and no tx_data_en is issued.

Optional Feature:
- Macro ETH_UPLOAD_PAD_EN.
- Defined: state PAD is inserted between FILL and ISSUE. If count<MIN_WORDS, one zero word is written per cycle at waddr=count (count++) until count==MIN_WORDS; tx_data_len reports the padded length. app_ready=0 during PAD.
- Undefined: there is no PAD state, short packets are sent at their true length, and the MIN_WORDS parameter is unused.

Test Plan:
- 4-word packet (0x11,0x22,0x33,0x44 with last on 0x44): writes at addr 0..3, then tx_data_en pulse with tx_data_len=4. tx_busy high 10 cycles then low: app_ready returns 1 the cycle after tx_busy falls.
- Packet of 365 words with MAX_WORDS=360: addresses 0..359 written, words 361..365 dropped with app_ready=1, tx_data_len=360, trunc_cnt=1.
- Single word with app_last: tx_data_len=1. With ETH_UPLOAD_PAD_EN defined: zeros written at addr 1..15, tx_data_len=16.
- tx_busy never asserted: tx_data_en pulse, then after 255 cycles timeout_cnt=1 and state back to FILL. The next 2-word packet starts at addr 0 with len=2.
- Reset asserted after 3 of 8 words: all outputs 0 immediately, no tx_data_en. A fresh 2-word packet writes addr 0..1 with len=2.
- Random app_valid gaps (50% duty) on a 100-word packet: exactly 100 writes with contiguous addresses 0..99, tx_data_len=100.
